// File: rtl/vehicle_sensor_conditioner_pkg.sv
// Shared traffic types: loop-detector debounce states and the R/Y/G light encoding
// used by traffic_controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        RISE_CHK = 2'd1,
        PRESENT  = 2'd2,
        FALL_CHK = 2'd3
    } det_state_e;

    typedef enum logic [2:0] {
        LIGHT_RED    = 3'b100,
        LIGHT_YELLOW = 3'b010,
        LIGHT_GREEN  = 3'b001
    } light_e;

endpackage

// File: rtl/vehicle_sensor_conditioner_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous external inputs.
// Asynchronous active-low reset clears both stages.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Minor-road loop detector conditioning: synchronize, debounce, latch request, detect stuck loop.
// Optional arrival counter enabled by defining VEHICLE_COUNT_EN.
module vehicle_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned STUCK_CYCLES = 64,
    parameter int unsigned COUNT_W      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               loop_raw,
    input  logic               served,
    output logic               sensor,
    output logic               presence,
    output logic               arrival,
    output logic               stuck_fault
`ifdef VEHICLE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] vehicle_count
`endif
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE);
    localparam int unsigned      STK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

    if (DEBOUNCE < 2 || STUCK_CYCLES <= DEBOUNCE || COUNT_W < 1) begin : g_param_check
        $error("vehicle_sensor_conditioner: invalid parameter set");
    end

    logic             sync_q;
    det_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STK_W-1:0] stk_q, stk_d;
    logic             presence_q, presence_d;
    logic             arrival_q, arrival_d;
    logic             sensor_q, sensor_d;
    logic             stuck_q, stuck_d;

    sync_2ff #(
        .WIDTH(1)
    ) u_loop_sync (
        .clk_i (clock),
        .rst_ni(reset),
        .d_i   (loop_raw),
        .q_o   (sync_q)
    );

    // One debounce counter serves both check states; it restarts at 1 on entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arrival_d = 1'b0;
        case (state_q)
            ABSENT: begin
                if (sync_q) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            RISE_CHK: begin
                if (!sync_q) begin
                    state_d = ABSENT;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = PRESENT;
                    arrival_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESENT: begin
                if (!sync_q) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            FALL_CHK: begin
                if (sync_q) begin
                    state_d = PRESENT;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ABSENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ABSENT;
        endcase
    end

    always_comb begin
        presence_d = (state_d == PRESENT) || (state_d == FALL_CHK);

        stk_d = stk_q;
        if (state_q == ABSENT) begin
            stk_d = '0;
        end else if ((state_q == PRESENT || state_q == FALL_CHK) && stk_q != STK_MAX) begin
            stk_d = stk_q + 1'b1;
        end
        stuck_d = (state_d != ABSENT) && (stk_d == STK_MAX);

        // A stuck loop must never hold a request against the major road.
        sensor_d = sensor_q;
        if (stuck_d) begin
            sensor_d = 1'b0;
        end else if (arrival_d) begin
            sensor_d = 1'b1;
        end else if (served && !presence_d) begin
            sensor_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ABSENT;
            cnt_q      <= '0;
            stk_q      <= '0;
            presence_q <= 1'b0;
            arrival_q  <= 1'b0;
            sensor_q   <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stk_q      <= stk_d;
            presence_q <= presence_d;
            arrival_q  <= arrival_d;
            sensor_q   <= sensor_d;
            stuck_q    <= stuck_d;
        end
    end

    assign sensor      = sensor_q;
    assign presence    = presence_q;
    assign arrival     = arrival_q;
    assign stuck_fault = stuck_q;

`ifdef VEHICLE_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (arrival_d && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign vehicle_count = count_q;
`endif

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Self-checking bench for vehicle_sensor_conditioner: directed scenarios plus random loop
// activity, checked every cycle against a run-length reference model.
module tb_vehicle_sensor_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned STK = 64;
    localparam int unsigned CW  = 8;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic loop_raw = 1'b0;
    logic served   = 1'b0;
    logic sensor, presence, arrival, stuck_fault;
`ifdef VEHICLE_COUNT_EN
    logic [CW-1:0] vehicle_count;
`endif

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model state
    bit m_s1, m_s2, m_pres, m_arr, m_stuck, m_sensor;
    int unsigned m_mism, m_held, m_count;

    always #5 clock = ~clock;

    vehicle_sensor_conditioner #(
        .DEBOUNCE    (DEB),
        .STUCK_CYCLES(STK),
        .COUNT_W     (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .loop_raw     (loop_raw),
        .served       (served),
        .sensor       (sensor),
        .presence     (presence),
        .arrival      (arrival),
        .stuck_fault  (stuck_fault)
`ifdef VEHICLE_COUNT_EN
        ,
        .vehicle_count(vehicle_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_s1 = 0; m_s2 = 0; m_pres = 0; m_arr = 0; m_stuck = 0; m_sensor = 0;
        m_mism = 0; m_held = 0; m_count = 0;
    endtask

    // Presence toggles once the synchronized level has disagreed with it DEB edges in a row.
    task automatic model_edge();
        bit sync_now, old_pres;
        sync_now = m_s2;
        old_pres = m_pres;
        m_s2 = m_s1;
        m_s1 = loop_raw;
        if (sync_now != m_pres) m_mism++;
        else m_mism = 0;
        m_arr = 0;
        if (m_mism == DEB) begin
            m_pres = !m_pres;
            m_mism = 0;
            m_arr  = m_pres;
        end
        if (old_pres) m_held = (m_held < STK) ? m_held + 1 : STK;
        else m_held = 0;
        m_stuck = m_pres && (m_held == STK);
        if (m_stuck) m_sensor = 0;
        else if (m_arr) m_sensor = 1;
        else if (served && !m_pres) m_sensor = 0;
        if (m_arr && m_count < (1 << CW) - 1) m_count++;
    endtask

    task automatic check_outputs();
        chk("presence", presence, m_pres);
        chk("arrival", arrival, m_arr);
        chk("sensor", sensor, m_sensor);
        chk("stuck_fault", stuck_fault, m_stuck);
`ifdef VEHICLE_COUNT_EN
        chk("vehicle_count", vehicle_count, m_count);
`endif
    endtask

    task automatic step();
        @(posedge clock);
        edge_n++;
        if (reset) model_edge();
        else m_clear();
        #1;
        check_outputs();
    endtask

    initial begin
        int start, rise;
        bit lvl, any_pres;
        int unsigned len;

        m_clear();
        #1 reset = 1'b0;

        // Reset hold with a toggling loop
        for (int i = 0; i < 5; i++) begin
            loop_raw = ~loop_raw;
            step();
        end
        loop_raw = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (10) step();

        // Clean arrival and served fall
        loop_raw = 1'b1;
        start = edge_n;
        while (!arrival && edge_n - start < 20) step();
        chk("arrival_latency", edge_n - start, 6);
        chk("sensor_at_arrival", sensor, 1);
        step();
        served = 1'b1;
        loop_raw = 1'b0;
        start = edge_n;
        while (presence && edge_n - start < 20) step();
        chk("fall_latency", edge_n - start, 6);
        chk("sensor_clear_on_fall", sensor, 0);
        served = 1'b0;
        repeat (4) step();

        // Glitch rejection: three high clocks never reach acceptance
        any_pres = 0;
        loop_raw = 1'b1;
        repeat (3) begin step(); any_pres |= presence; end
        loop_raw = 1'b0;
        repeat (8) begin step(); any_pres |= presence | arrival | sensor; end
        chk("glitch_rejected", any_pres, 0);

        // One-clock dip while present
        loop_raw = 1'b1;
        repeat (10) step();
        loop_raw = 1'b0;
        step();
        loop_raw = 1'b1;
        any_pres = 1;
        repeat (8) begin step(); any_pres &= presence; end
        chk("dip_holds_presence", any_pres, 1);

        // Served while present keeps the request; later fall clears only once served
        served = 1'b1;
        repeat (20) step();
        chk("served_while_present", sensor, 1);
        served = 1'b0;
        loop_raw = 1'b0;
        repeat (10) step();
        chk("sensor_held_unserved", sensor, 1);
        served = 1'b1;
        step();
        chk("sensor_cleared_served", sensor, 0);
        served = 1'b0;

        // Stuck loop
        loop_raw = 1'b1;
        start = edge_n;
        while (!arrival && edge_n - start < 20) step();
        rise = edge_n;
        while (!stuck_fault && edge_n - rise < 80) step();
        chk("stuck_latency", edge_n - rise, STK);
        chk("stuck_forces_sensor", sensor, 0);
        repeat (30) step();
        loop_raw = 1'b0;
        start = edge_n;
        while (presence && edge_n - start < 20) step();
        chk("stuck_clear_on_absent", stuck_fault, 0);
        chk("sensor_after_stuck", sensor, 0);
        repeat (3) step();

        // Asynchronous reset while present with loop still high
        loop_raw = 1'b1;
        start = edge_n;
        while (!presence && edge_n - start < 20) step();
        repeat (3) step();
        #2 reset = 1'b0;
        m_clear();
        #1;
        chk("async_rst_presence", presence, 0);
        chk("async_rst_sensor", sensor, 0);
        chk("async_rst_arrival", arrival, 0);
        chk("async_rst_stuck", stuck_fault, 0);
        repeat (2) step();
        @(negedge clock);
        reset = 1'b1;
        start = edge_n;
        while (!arrival && edge_n - start < 20) step();
        chk("rearm_latency", edge_n - start, 6);
`ifdef VEHICLE_COUNT_EN
        chk("count_one", vehicle_count, 1);
`endif

        // Random loop activity with occasional stuck-length holds
        lvl = 1'b1;
        for (int r = 0; r < 250; r++) begin
            len = ($urandom_range(0, 19) == 0) ? 80 : $urandom_range(1, 8);
            lvl = !lvl;
            loop_raw = lvl;
            for (int k = 0; k < int'(len); k++) begin
                served = ($urandom_range(0, 3) == 0);
                step();
            end
        end

        // Many arrivals to exercise counter saturation
        for (int a = 0; a < 300; a++) begin
            loop_raw = 1'b1;
            repeat (7) begin served = $urandom_range(0, 1); step(); end
            loop_raw = 1'b0;
            repeat (7) begin served = $urandom_range(0, 1); step(); end
        end
`ifdef VEHICLE_COUNT_EN
        chk("count_saturated", vehicle_count, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
